flipflop_jk_bank: RTL and testbench
===================================

# flipflop_jk_bank

Parametrised bank of WIDTH independent JK flip-flops sharing one clock, with synchronous reset, clock enable, parallel load, per-edge change flags and a saturating toggle-event counter. It is the multi-bit successor of the single JK flip-flop and serves as a generic state register for small control blocks and as a teaching block for cocotb benches.

## Interface
Parameters:
- WIDTH, 4, number of JK channels (1..32)
- RESET_VALUE, 0, WIDTH-bit value loaded into o_q on reset
- CNT_WIDTH, 8, width of the toggle-event counter (≥ $clog2(WIDTH+1))

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_en  in  1  clock enable for JK update
- i_load  in  1  parallel load strobe
- i_d  in  WIDTH  parallel load data
- i_j  in  WIDTH  per-channel J input
- i_k  in  WIDTH  per-channel K input
- o_q  out  WIDTH  flip-flop state
- o_qn  out  WIDTH  always ~o_q
- o_changed  out  WIDTH  bits of o_q that changed on the last rising edge
- o_toggle_cnt  out  CNT_WIDTH  saturating count of toggle events
- o_sat  out  1  high while o_toggle_cnt = 2^CNT_WIDTH−1

## Operation
- Priority per rising edge: i_rst > i_load > i_en > hold.
- Reset: o_q ← RESET_VALUE, o_changed ← 0, o_toggle_cnt ← 0, o_sat ← 0. o_qn therefore ~RESET_VALUE.
- Load (i_rst=0, i_load=1): o_q ← i_d regardless of i_en, i_j, i_k; counter unchanged.
- JK update (i_rst=0, i_load=0, i_en=1), per bit n:
  - J=0,K=0: hold
  - J=0,K=1: reset to 0
  - J=1,K=0: set to 1
  - J=1,K=1: toggle
- Hold (i_en=0, no load/reset): o_q unchanged, counter unchanged.
- o_changed ← q_next XOR o_q on every non-reset edge (all-zero on hold).
- Toggle counter: on a JK-update edge add popcount(i_j & i_k) (bits in toggle mode, counted even if value would not differ); sum computed in CNT_WIDTH+1 bits, clamped to 2^CNT_WIDTH−1. No wrap-around. Cleared only by i_rst.
- o_sat is registered, asserted on the same edge the counter reaches max, stays high until reset.
- X/Z on i_j/i_k with i_en=0 has no effect on state.

## Timing
- One-cycle latency: inputs sampled on rising edge t, o_q/o_changed/o_toggle_cnt/o_sat valid after edge t.
- o_qn is combinational inverse of the o_q register; no extra latency.
- Reset asserted mid-operation overrides any concurrent load/enable on that edge; first update after release occurs on the first edge with i_rst=0.
- Simultaneous i_load and i_en: load wins, no toggle counted.
- No combinational path from any input to any output.

## Test plan
WIDTH=4, RESET_VALUE=4'b1010, CNT_WIDTH=3:
- Hold i_rst=1 two edges, then release -> o_q=1010, o_qn=0101, o_changed=0000, o_toggle_cnt=0, o_sat=0.
- i_en=1, J=1111, K=0000 one edge, then J=0000, K=1111 -> o_q=1111 (o_changed=0101), then o_q=0000 (o_changed=1111); counter stays 0.
- i_en=1, J=K=1111 for one edge from o_q=0000 -> o_q=1111, o_toggle_cnt=4; second edge -> o_q=0000, cnt=7, o_sat=1; third edge -> cnt stays 7 (no wrap).
- i_load=1, i_en=1, i_d=0110, J=K=1111 -> o_q=0110, counter unchanged.
- i_en=0 with random J/K for 5 edges -> o_q constant, o_changed=0000 each edge.
- Mid-sequence i_rst=1 together with i_load=1, i_d=0001 -> o_q=1010, cnt=0, o_sat=0 on that edge.

Source files
------------

// File: rtl/flipflop_jk_bank.sv
// flipflop_jk_bank: WIDTH independent JK flip-flops on one clock, with
// synchronous reset, clock enable, parallel load, per-edge change flags
// and a saturating toggle-event counter.
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_rst        synchronous active-high reset
//   i_en         enable for the JK update
//   i_load       parallel load strobe, beats i_en
//   i_d          parallel load data
//   i_j, i_k     per-channel J and K inputs
//   o_q, o_qn    flip-flop state and its inverse
//   o_changed    bits of o_q that changed on the last edge
//   o_toggle_cnt saturating count of J=K=1 bit-events
//   o_sat        high while the counter sits at its maximum
module flipflop_jk_bank #(
  parameter int unsigned      WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      CNT_WIDTH   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_load,
  input  logic [WIDTH-1:0]     i_d,
  input  logic [WIDTH-1:0]     i_j,
  input  logic [WIDTH-1:0]     i_k,
  output logic [WIDTH-1:0]     o_q,
  output logic [WIDTH-1:0]     o_qn,
  output logic [WIDTH-1:0]     o_changed,
  output logic [CNT_WIDTH-1:0] o_toggle_cnt,
  output logic                 o_sat
);

  localparam logic [CNT_WIDTH:0] CNT_MAX =
    {1'b0, {CNT_WIDTH{1'b1}}};

  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     chg_q, chg_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 sat_q, sat_d;

  logic [WIDTH-1:0]     tgl;
  logic [CNT_WIDTH:0]   pop;
  logic [CNT_WIDTH:0]   sum;

  assign tgl = i_j & i_k;

  // CNT_WIDTH >= clog2(WIDTH+1), so the popcount never overflows here.
  always_comb begin
    pop = '0;
    for (int n = 0; n < WIDTH; n++) begin
      pop = pop + {{CNT_WIDTH{1'b0}}, tgl[n]};
    end
  end

  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    sum   = '0;
    if (i_load) begin
      q_d = i_d;
    end else if (i_en) begin
      // JK characteristic: Q+ = J&~Q | ~K&Q
      q_d = (i_j & ~q_q) | (~i_k & q_q);
      sum = {1'b0, cnt_q} + pop;
      // One extra bit of headroom so the clamp catches any overflow.
      if (sum > CNT_MAX) begin
        cnt_d = CNT_MAX[CNT_WIDTH-1:0];
      end else begin
        cnt_d = sum[CNT_WIDTH-1:0];
      end
    end
    chg_d = q_d ^ q_q;
    sat_d = (cnt_d == CNT_MAX[CNT_WIDTH-1:0]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      q_q   <= RESET_VALUE;
      chg_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      chg_q <= chg_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign o_q          = q_q;
  assign o_qn         = ~q_q;
  assign o_changed    = chg_q;
  assign o_toggle_cnt = cnt_q;
  assign o_sat        = sat_q;

endmodule

// File: tb/tb_flipflop_jk_bank.sv
// tb_flipflop_jk_bank: directed bench for flipflop_jk_bank with
// WIDTH=4, RESET_VALUE=4'b1010, CNT_WIDTH=3.
module tb_flipflop_jk_bank;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] d;
  logic [3:0] j;
  logic [3:0] k;
  logic [3:0] q;
  logic [3:0] qn;
  logic [3:0] chg;
  logic [2:0] cnt;
  logic       sat;

  int n_chk;
  int n_pass;

  flipflop_jk_bank #(
    .WIDTH      (4),
    .RESET_VALUE(4'b1010),
    .CNT_WIDTH  (3)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_load      (load),
    .i_d         (d),
    .i_j         (j),
    .i_k         (k),
    .o_q         (q),
    .o_qn        (qn),
    .o_changed   (chg),
    .o_toggle_cnt(cnt),
    .o_sat       (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0;
    d = 4'b0000; j = 4'b0000; k = 4'b0000;
    step();
    step();
    n_chk++; if (q !== 4'b1010) $display("FAIL rst_q got %b want 1010", q); else n_pass++;
    n_chk++; if (qn !== 4'b0101) $display("FAIL rst_qn got %b want 0101", qn); else n_pass++;
    n_chk++; if (chg !== 4'b0000) $display("FAIL rst_chg got %b want 0000", chg); else n_pass++;
    n_chk++; if (cnt !== 3'd0) $display("FAIL rst_cnt got %0d want 0", cnt); else n_pass++;
    n_chk++; if (sat !== 1'b0) $display("FAIL rst_sat got %b want 0", sat); else n_pass++;
    rst = 1'b0;
    step();
    n_chk++; if (q !== 4'b1010) $display("FAIL rel_q got %b want 1010", q); else n_pass++;
    n_chk++; if (chg !== 4'b0000) $display("FAIL rel_chg got %b want 0000", chg); else n_pass++;
  endtask

  task automatic test_set_clear();
    en = 1'b1; j = 4'b1111; k = 4'b0000;
    step();
    n_chk++; if (q !== 4'b1111) $display("FAIL set_q got %b want 1111", q); else n_pass++;
    n_chk++; if (chg !== 4'b0101) $display("FAIL set_chg got %b want 0101", chg); else n_pass++;
    n_chk++; if (cnt !== 3'd0) $display("FAIL set_cnt got %0d want 0", cnt); else n_pass++;
    j = 4'b0000; k = 4'b1111;
    step();
    n_chk++; if (q !== 4'b0000) $display("FAIL clr_q got %b want 0000", q); else n_pass++;
    n_chk++; if (qn !== 4'b1111) $display("FAIL clr_qn got %b want 1111", qn); else n_pass++;
    n_chk++; if (chg !== 4'b1111) $display("FAIL clr_chg got %b want 1111", chg); else n_pass++;
    n_chk++; if (cnt !== 3'd0) $display("FAIL clr_cnt got %0d want 0", cnt); else n_pass++;
  endtask

  task automatic test_toggle_sat();
    en = 1'b1; j = 4'b1111; k = 4'b1111;
    step();
    n_chk++; if (q !== 4'b1111) $display("FAIL tg1_q got %b want 1111", q); else n_pass++;
    n_chk++; if (cnt !== 3'd4) $display("FAIL tg1_cnt got %0d want 4", cnt); else n_pass++;
    n_chk++; if (sat !== 1'b0) $display("FAIL tg1_sat got %b want 0", sat); else n_pass++;
    step();
    n_chk++; if (q !== 4'b0000) $display("FAIL tg2_q got %b want 0000", q); else n_pass++;
    n_chk++; if (cnt !== 3'd7) $display("FAIL tg2_cnt got %0d want 7", cnt); else n_pass++;
    n_chk++; if (sat !== 1'b1) $display("FAIL tg2_sat got %b want 1", sat); else n_pass++;
    step();
    n_chk++; if (q !== 4'b1111) $display("FAIL tg3_q got %b want 1111", q); else n_pass++;
    n_chk++; if (cnt !== 3'd7) $display("FAIL tg3_cnt got %0d want 7", cnt); else n_pass++;
    n_chk++; if (sat !== 1'b1) $display("FAIL tg3_sat got %b want 1", sat); else n_pass++;
  endtask

  task automatic test_load();
    load = 1'b1; en = 1'b1; d = 4'b0110;
    j = 4'b1111; k = 4'b1111;
    step();
    load = 1'b0;
    n_chk++; if (q !== 4'b0110) $display("FAIL ld_q got %b want 0110", q); else n_pass++;
    n_chk++; if (chg !== 4'b1001) $display("FAIL ld_chg got %b want 1001", chg); else n_pass++;
    n_chk++; if (cnt !== 3'd7) $display("FAIL ld_cnt got %0d want 7", cnt); else n_pass++;
    n_chk++; if (sat !== 1'b1) $display("FAIL ld_sat got %b want 1", sat); else n_pass++;
  endtask

  task automatic test_hold();
    en = 1'b0; load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      j = 4'($urandom);
      k = 4'($urandom);
      step();
      n_chk++; if (q !== 4'b0110) $display("FAIL hold%0d_q got %b want 0110", i, q); else n_pass++;
      n_chk++; if (chg !== 4'b0000) $display("FAIL hold%0d_chg got %b want 0000", i, chg); else n_pass++;
    end
    j = 4'bxxxx; k = 4'bzzzz;
    step();
    n_chk++; if (q !== 4'b0110) $display("FAIL holdx_q got %b want 0110", q); else n_pass++;
    n_chk++; if (chg !== 4'b0000) $display("FAIL holdx_chg got %b want 0000", chg); else n_pass++;
    n_chk++; if (cnt !== 3'd7) $display("FAIL holdx_cnt got %0d want 7", cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; load = 1'b1; en = 1'b1; d = 4'b0001;
    j = 4'b1111; k = 4'b1111;
    step();
    rst = 1'b0; load = 1'b0;
    n_chk++; if (q !== 4'b1010) $display("FAIL mrst_q got %b want 1010", q); else n_pass++;
    n_chk++; if (cnt !== 3'd0) $display("FAIL mrst_cnt got %0d want 0", cnt); else n_pass++;
    n_chk++; if (sat !== 1'b0) $display("FAIL mrst_sat got %b want 0", sat); else n_pass++;
    n_chk++; if (chg !== 4'b0000) $display("FAIL mrst_chg got %b want 0000", chg); else n_pass++;
  endtask

  task automatic test_mixed();
    // 1010: b3 toggle, b2 set, b1 clear, b0 hold
    en = 1'b1; j = 4'b1100; k = 4'b1010;
    step();
    n_chk++; if (q !== 4'b0100) $display("FAIL mix_q got %b want 0100", q); else n_pass++;
    n_chk++; if (chg !== 4'b1110) $display("FAIL mix_chg got %b want 1110", chg); else n_pass++;
    n_chk++; if (cnt !== 3'd1) $display("FAIL mix_cnt got %0d want 1", cnt); else n_pass++;
    j = 4'b0011; k = 4'b0011;
    step();
    n_chk++; if (q !== 4'b0111) $display("FAIL mix2_q got %b want 0111", q); else n_pass++;
    n_chk++; if (chg !== 4'b0011) $display("FAIL mix2_chg got %b want 0011", chg); else n_pass++;
    n_chk++; if (cnt !== 3'd3) $display("FAIL mix2_cnt got %0d want 3", cnt); else n_pass++;
    n_chk++; if (sat !== 1'b0) $display("FAIL mix2_sat got %b want 0", sat); else n_pass++;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_set_clear();
    test_toggle_sat();
    test_load();
    test_hold();
    test_reset_mid();
    test_mixed();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
